eis_unit: RTL
=============

EIS_UNIT -- requirements
Module: eis_unit

Interface
REQ-001 SHALL have parameter W, default 16, giving the operand width; legal values are even numbers 8..32.
REQ-002 SHALL have parameter CW, default $clog2(W)+2 (6 at W=16), giving the width of the signed shift-count field.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 SHALL have port op, input, 2 bits: operation select (0 MUL, 1 DIV, 2 ASH, 3 ASHC).
REQ-007 SHALL have port src, input, W bits: multiplier, divisor, or shift count in src[CW-1:0].
REQ-008 SHALL have port dst_hi, input, W bits: MUL multiplicand, ASH operand, or DIV/ASHC high word.
REQ-009 SHALL have port dst_lo, input, W bits: DIV/ASHC low word; ignored by MUL/ASH.
REQ-010 SHALL have port busy, output, 1 bit: high from the accepting edge until done.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse marking results valid.
REQ-012 SHALL have port res_hi, output, W bits: product high, quotient, or shifted word (ASHC high).
REQ-013 SHALL have port res_lo, output, W bits: product low, remainder, ASHC low, or 0 for ASH.
REQ-014 SHALL have port flags, output, 4 bits: {N,Z,V,C}.
REQ-015 SHALL have port ccmask, output, 4 bits: always 4'b1111 on done.

Function
REQ-016 SHALL accept an operation when start=1 in IDLE; all operands are latched on that edge; start while busy SHALL be ignored.
REQ-017 SHALL use states IDLE, PREP (abs/sign capture), RUN (iteration counter), FIX (sign correction and flags), DONE (1 cycle, done=1), then return to IDLE.
REQ-018 MUL SHALL form the signed W x W -> 2W product by radix-2 shift-add; done asserts W+2 cycles after the accepting edge.
REQ-019 MUL flags: N = product[2W-1]; Z = product==0; V = 0; C = 1 iff product is not the sign extension of res_lo.
REQ-020 DIV SHALL divide the signed 2W {dst_hi,dst_lo} by signed src using W non-restoring or restoring steps on magnitudes; the quotient sign is the XOR of the operand signs and the remainder takes the dividend's sign; done asserts W+2 cycles after accept.
REQ-021 DIV with src==0 SHALL skip RUN; done asserts 2 cycles after accept, res = {dst_hi,dst_lo} unchanged, flags V=1, C=1, N=0, Z=0.
REQ-022 DIV whose quotient does not fit in W signed bits SHALL give res = {dst_hi,dst_lo} unchanged, V=1, C=0, N=0, Z=0 at normal latency.
REQ-023 DIV normal flags: N = quotient sign; Z = quotient==0; V = 0; C = 0.
REQ-024 ASH/ASHC SHALL shift by the signed count src[CW-1:0], one bit per RUN cycle; a positive count shifts left with 0 fill; a negative count shifts right arithmetically; the operand is W bits for ASH and 2W bits for ASHC.
REQ-025 ASH/ASHC latency SHALL be |count|+2 cycles; a count of 0 gives latency 2 with the operand unchanged.
REQ-026 ASH/ASHC flags: C = last bit shifted out (0 if count=0); V = 1 if the sign bit changed on any step; N and Z from the result.
REQ-027 res_hi, res_lo and flags SHALL hold their values from done until the next accept; they SHALL NOT change mid-operation.

Reset
REQ-028 When reset_n=0 at an edge, the block SHALL go to IDLE with busy=0, done=0, res_hi=0, res_lo=0, flags=0 and ccmask=0, from any state including mid-RUN.
REQ-029 An operation interrupted by reset SHALL be discarded, with no done pulse.

Structure
REQ-030 Package eis_pkg SHALL hold the op encodings, the state enum and the flag bit indices N=3, Z=2, V=1, C=0.
REQ-031 One step of the division datapath SHALL be a sub-module eis_divstep (combinational, parametrised by W); everything else SHALL be in eis_unit.

Verification (W=16)
REQ-032 MUL of dst_hi=0x7FFF by src=0x0002 -> res 0x0000/0xFFFE, NZVC=0001, done 18 cycles after accept.
REQ-033 MUL of -3 by 5 -> res 0xFFFF/0xFFF1, NZVC=1000; MUL of 0 by 0x1234 -> NZVC=0100.
REQ-034 DIV of 0x0000/0x0064 by 7 -> res_hi=0x000E, res_lo=0x0002, NZVC=0000; DIV of 0xFFFF/0xFF9C (-100) by 7 -> 0xFFF2/0xFFFE, N=1.
REQ-035 DIV by 0 -> operands unchanged, NZVC=0011, done 2 cycles after accept; DIV of 0x4000/0x0000 by 1 -> NZVC=0010, operands unchanged.
REQ-036 ASH of 0x4000 by +1 -> 0x8000, NZVC=1010; ASH of 0x0003 by 0x3F (-1) -> 0x0001, C=1; ASHC of 0x0000/0x8000 by +1 -> 0x0001/0x0000, NZVC=0000.
REQ-037 start held high during a MUL -> exactly one done; reset_n=0 mid-MUL -> busy=0, done=0 at the next edge, with no later done.

Source files
------------

// File: rtl/eis_pkg.sv
// eis_pkg: shared definitions for the extended-instruction-set arithmetic unit.
//   op_e       - operation encodings presented on the op port
//   state_e    - sequencer states of eis_unit
//   FLAG_*     - bit positions of N, Z, V, C inside the flags word
package eis_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,
    OP_DIV  = 2'd1,
    OP_ASH  = 2'd2,
    OP_ASHC = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/eis_divstep.sv
// eis_divstep: one restoring-division step on unsigned magnitudes.
//   rem_in   - partial remainder entering the step (always < divisor)
//   bit_in   - next dividend bit shifted into the remainder
//   divisor  - divisor magnitude
//   rem_out  - partial remainder after the step
//   q_bit    - quotient bit produced by the step
module eis_divstep #(
  parameter int W = 16
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] trial;
  logic [W:0] diff;

  assign trial = {rem_in, bit_in};
  assign diff  = trial - {1'b0, divisor};

  // rem_in < divisor keeps the trial below 2*divisor, so the result fits W bits.
  always_comb begin
    if (trial >= {1'b0, divisor}) begin
      q_bit   = 1'b1;
      rem_out = diff[W-1:0];
    end else begin
      q_bit   = 1'b0;
      rem_out = trial[W-1:0];
    end
  end

endmodule

// File: rtl/eis_unit.sv
// eis_unit: multi-cycle signed MUL / DIV / ASH / ASHC unit.
//   clk, reset_n     - clock and synchronous active-low reset
//   start, op        - request and operation select, sampled only in IDLE
//   src              - multiplier, divisor, or signed shift count in src[CW-1:0]
//   dst_hi, dst_lo   - multiplicand / dividend / shift operand words
//   busy, done       - operation in progress / one-cycle result-valid pulse
//   res_hi, res_lo   - result words, held from done until the next result
//   flags, ccmask    - {N,Z,V,C} and the condition-code write mask
module eis_unit
  import eis_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = $clog2(W) + 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] src,
  input  logic [W-1:0] dst_hi,
  input  logic [W-1:0] dst_lo,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo,
  output logic [3:0]   flags,
  output logic [3:0]   ccmask
);

  state_e          state, state_nxt;
  op_e             op_r;
  logic [W-1:0]    src_r, opnd_hi, opnd_lo;
  logic [W-1:0]    acc_hi, acc_lo, mag;
  logic            neg_res, neg_dvd, shr, v_acc, c_acc, ovf;
  logic [CW-1:0]   cnt, cnt_start, shamt_in, shamt_r;
  logic [2*W-1:0]  dvd_mag, prod, prod_s;
  logic [W:0]      mul_sum;
  logic [W-1:0]    ds_rem, q_s, r_s;
  logic            ds_q, q_fits, divz;
  logic [W-1:0]    fix_hi, fix_lo;
  logic [3:0]      fix_flags;

  function automatic logic [W-1:0] abs_w(input logic [W-1:0] x);
    return x[W-1] ? -x : x;
  endfunction

  function automatic logic [2*W-1:0] abs_2w(input logic [2*W-1:0] x);
    return x[2*W-1] ? -x : x;
  endfunction

  // ---------------------------------------------------------------- sequencer
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_PREP;
      ST_PREP: begin
        busy      = 1'b1;
        // Divide-by-zero and zero shift counts go straight to FIX.
        state_nxt = (cnt == '0) ? ST_FIX : ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        busy      = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- accept: step count
  assign shamt_in = src[CW-1:0];

  always_comb begin
    cnt_start = CW'(W);
    case (op_e'(op))
      OP_MUL:  cnt_start = CW'(W);
      OP_DIV:  cnt_start = (src == '0) ? '0 : CW'(W);
      default: cnt_start = shamt_in[CW-1] ? -shamt_in : shamt_in;
    endcase
  end

  // ---------------------------------------------------------------- PREP/RUN datapath
  assign shamt_r = src_r[CW-1:0];
  assign dvd_mag = abs_2w({opnd_hi, opnd_lo});
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag} : '0);

  eis_divstep #(.W(W)) u_divstep (
    .rem_in  (acc_hi),
    .bit_in  (acc_lo[W-1]),
    .divisor (mag),
    .rem_out (ds_rem),
    .q_bit   (ds_q)
  );

  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: begin
        if (start) begin
          op_r    <= op_e'(op);
          src_r   <= src;
          opnd_hi <= dst_hi;
          opnd_lo <= dst_lo;
          cnt     <= cnt_start;
        end
      end
      ST_PREP: begin
        v_acc   <= 1'b0;
        c_acc   <= 1'b0;
        neg_res <= opnd_hi[W-1] ^ src_r[W-1];
        neg_dvd <= opnd_hi[W-1];
        mag     <= abs_w(src_r);
        shr     <= shamt_r[CW-1];
        // A high dividend half >= divisor means the quotient needs > W bits.
        ovf     <= dvd_mag[2*W-1:W] >= abs_w(src_r);
        case (op_r)
          OP_MUL: begin
            mag    <= abs_w(opnd_hi);
            acc_hi <= '0;
            acc_lo <= abs_w(src_r);
          end
          OP_DIV: begin
            acc_hi <= dvd_mag[2*W-1:W];
            acc_lo <= dvd_mag[W-1:0];
          end
          OP_ASH: begin
            acc_hi <= opnd_hi;
            acc_lo <= '0;
          end
          default: begin
            acc_hi <= opnd_hi;
            acc_lo <= opnd_lo;
          end
        endcase
      end
      ST_RUN: begin
        cnt <= cnt - CW'(1);
        case (op_r)
          OP_MUL: begin
            acc_hi <= mul_sum[W:1];
            acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
          end
          OP_DIV: begin
            acc_hi <= ds_rem;
            acc_lo <= {acc_lo[W-2:0], ds_q};
          end
          default: begin
            if (shr) begin
              c_acc  <= (op_r == OP_ASH) ? acc_hi[0] : acc_lo[0];
              acc_hi <= {acc_hi[W-1], acc_hi[W-1:1]};
              if (op_r == OP_ASHC) acc_lo <= {acc_hi[0], acc_lo[W-1:1]};
            end else begin
              // acc_lo stays zero for ASH, so this also gives the 0 fill.
              c_acc  <= acc_hi[W-1];
              v_acc  <= v_acc | (acc_hi[W-1] ^ acc_hi[W-2]);
              acc_hi <= {acc_hi[W-2:0], acc_lo[W-1]};
              acc_lo <= {acc_lo[W-2:0], 1'b0};
            end
          end
        endcase
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- FIX: sign correction and flags
  assign prod   = {acc_hi, acc_lo};
  assign prod_s = neg_res ? -prod : prod;
  assign q_s    = neg_res ? -acc_lo : acc_lo;
  assign r_s    = neg_dvd ? -acc_hi : acc_hi;
  assign divz   = (src_r == '0);
  // A negative quotient may reach magnitude 2^(W-1); a positive one may not.
  assign q_fits = !ovf && (!acc_lo[W-1] ||
                  (neg_res && (acc_lo == {1'b1, {(W-1){1'b0}}})));

  always_comb begin
    fix_hi    = acc_hi;
    fix_lo    = acc_lo;
    fix_flags = '0;
    case (op_r)
      OP_MUL: begin
        fix_hi            = prod_s[2*W-1:W];
        fix_lo            = prod_s[W-1:0];
        fix_flags[FLAG_N] = prod_s[2*W-1];
        fix_flags[FLAG_Z] = (prod_s == '0);
        fix_flags[FLAG_C] = (prod_s[2*W-1:W] != {W{prod_s[W-1]}});
      end
      OP_DIV: begin
        if (divz || !q_fits) begin
          fix_hi            = opnd_hi;
          fix_lo            = opnd_lo;
          fix_flags[FLAG_V] = 1'b1;
          fix_flags[FLAG_C] = divz;
        end else begin
          fix_hi            = q_s;
          fix_lo            = r_s;
          fix_flags[FLAG_N] = q_s[W-1];
          fix_flags[FLAG_Z] = (q_s == '0);
        end
      end
      default: begin
        fix_flags[FLAG_N] = acc_hi[W-1];
        fix_flags[FLAG_Z] = ({acc_hi, acc_lo} == '0);
        fix_flags[FLAG_V] = v_acc;
        fix_flags[FLAG_C] = c_acc;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res_hi <= '0;
      res_lo <= '0;
      flags  <= '0;
      ccmask <= '0;
    end else if (state == ST_FIX) begin
      res_hi <= fix_hi;
      res_lo <= fix_lo;
      flags  <= fix_flags;
      ccmask <= 4'b1111;
    end
  end

endmodule
